// File: rtl/tpram_sync.sv
// rtl/tpram_sync.sv - single-clock true dual-port RAM, registered reads, same-port write-first
// Optional cross-port write forwarding when TPRAM_FWD_EN is defined.
module tpram_sync #(
    parameter int aw = 11,
    parameter int dw = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce_a,
    input  logic          we_a,
    input  logic          oe_a,
    input  logic [aw-1:0] addr_a,
    input  logic [dw-1:0] di_a,
    output logic [dw-1:0] do_a,
    input  logic          ce_b,
    input  logic          we_b,
    input  logic          oe_b,
    input  logic [aw-1:0] addr_b,
    input  logic [dw-1:0] di_b,
    output logic [dw-1:0] do_b
);

    localparam int depth = 1 << aw;

    logic [dw-1:0] r_mem [depth];
    logic [dw-1:0] r_q_a;
    logic [dw-1:0] r_q_b;

    logic w_wr_a;
    logic w_wr_b;
    logic w_fwd_a;
    logic w_fwd_b;

    assign w_wr_a = ce_a & we_a & ~rst;
    assign w_wr_b = ce_b & we_b & ~rst;

`ifdef TPRAM_FWD_EN
    // A reading port takes the other port's write data when addresses match.
    assign w_fwd_a = w_wr_b && (addr_b == addr_a);
    assign w_fwd_b = w_wr_a && (addr_a == addr_b);
`else
    assign w_fwd_a = 1'b0;
    assign w_fwd_b = 1'b0;
`endif

    // Port A is written last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (w_wr_b) begin
            r_mem[addr_b] <= di_b;
        end
        if (w_wr_a) begin
            r_mem[addr_a] <= di_a;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q_a <= '0;
        end else if (ce_a) begin
            if (we_a) begin
                r_q_a <= di_a;
            end else if (w_fwd_a) begin
                r_q_a <= di_b;
            end else begin
                r_q_a <= r_mem[addr_a];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q_b <= '0;
        end else if (ce_b) begin
            if (we_b) begin
                r_q_b <= di_b;
            end else if (w_fwd_b) begin
                r_q_b <= di_a;
            end else begin
                r_q_b <= r_mem[addr_b];
            end
        end
    end

    assign do_a = oe_a ? r_q_a : '0;
    assign do_b = oe_b ? r_q_b : '0;

endmodule

// File: tb/tb_tpram_sync.sv
// tb/tb_tpram_sync.sv - self-checking bench for tpram_sync against an array reference model
module tb_tpram_sync;

    localparam int AW = 11;
    localparam int DW = 8;
`ifdef TPRAM_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          ce_a, we_a, oe_a, ce_b, we_b, oe_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] di_a, di_b, do_a, do_b;

    tpram_sync #(.aw(AW), .dw(DW)) dut (
        .clk(clk), .rst(rst),
        .ce_a(ce_a), .we_a(we_a), .oe_a(oe_a), .addr_a(addr_a), .di_a(di_a), .do_a(do_a),
        .ce_b(ce_b), .we_b(we_b), .oe_b(oe_b), .addr_b(addr_b), .di_b(di_b), .do_b(do_b)
    );

    logic [7:0] em [2048];
    bit         ek [2048];
    logic [7:0] qa, qb;
    bit         ka, kb;
    int         n_checks = 0;
    int         n_pass = 0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    endtask

    task automatic model_port(input bit ce, input bit we, input logic [10:0] a, input logic [7:0] d,
                              input bit owr, input logic [10:0] oa, input logic [7:0] od,
                              inout logic [7:0] q, inout bit k);
        if (rst) begin
            q = 8'h00; k = 1'b1;
        end else if (ce) begin
            if (we) begin
                q = d; k = 1'b1;
            end else if (FWD && owr && oa == a) begin
                q = od; k = 1'b1;
            end else begin
                q = em[a]; k = ek[a];
            end
        end
    endtask

    task automatic cycle();
        bit wa, wb;
        wa = ce_a && we_a;
        wb = ce_b && we_b;
        model_port(ce_a, we_a, addr_a, di_a, wb, addr_b, di_b, qa, ka);
        model_port(ce_b, we_b, addr_b, di_b, wa, addr_a, di_a, qb, kb);
        if (!rst) begin
            if (wb) begin em[addr_b] = di_b; ek[addr_b] = 1'b1; end
            if (wa) begin em[addr_a] = di_a; ek[addr_a] = 1'b1; end
        end
        @(posedge clk);
        #1;
        if (!oe_a) check("do_a_oe", do_a, 8'h00);
        else if (ka) check("do_a", do_a, qa);
        if (!oe_b) check("do_b_oe", do_b, 8'h00);
        else if (kb) check("do_b", do_b, qb);
    endtask

    task automatic idle();
        rst = 1'b0;
        ce_a = 1'b0; we_a = 1'b0; oe_a = 1'b1;
        ce_b = 1'b0; we_b = 1'b0; oe_b = 1'b1;
    endtask

    task automatic wr_a(input logic [10:0] a, input logic [7:0] d);
        idle(); ce_a = 1'b1; we_a = 1'b1; addr_a = a; di_a = d;
    endtask

    task automatic rd_b(input logic [10:0] a);
        idle(); ce_b = 1'b1; addr_b = a;
    endtask

    initial begin
        logic [10:0] ra;
        addr_a = '0; addr_b = '0; di_a = '0; di_b = '0;
        qa = 8'h00; qb = 8'h00; ka = 1'b0; kb = 1'b0;
        for (int i = 0; i < 2048; i++) begin em[i] = 8'h00; ek[i] = 1'b0; end

        idle(); rst = 1'b1;
        cycle();
        check("rst_a", do_a, 8'h00);
        check("rst_b", do_b, 8'h00);

        wr_a(11'h010, 8'hA5); cycle();
        rd_b(11'h010); cycle();
        check("basic_rd", do_b, 8'hA5);

        rd_b(11'h100); ce_b = 1'b0; cycle();
        check("ce_b_hold", do_b, 8'hA5);
        idle(); oe_b = 1'b0; #1;
        check("oe_b_comb", do_b, 8'h00);
        idle(); ce_a = 1'b0; we_a = 1'b1; addr_a = 11'h010; di_a = 8'hFF; cycle();
        rd_b(11'h010); cycle();
        check("ce_a_nowr", do_b, 8'hA5);

        for (int i = 0; i < 2048; i++) begin
            wr_a(i[10:0], i[7:0]); cycle();
        end
        for (int j = 0; j < 2048; j++) begin
            ra = 11'h7F0 + j[10:0];
            rd_b(ra); cycle();
            check("full", do_b, ra[7:0]);
        end

        wr_a(11'h100, 8'h11); cycle();
        wr_a(11'h100, 8'h3C); ce_b = 1'b1; addr_b = 11'h100; cycle();
        check("fwd", do_b, FWD ? 8'h3C : 8'h11);

        wr_a(11'h055, 8'h55); cycle();
        idle(); ce_a = 1'b1; addr_a = 11'h055; cycle();
        check("pre_rst", do_a, 8'h55);
        wr_a(11'h055, 8'h99); rst = 1'b1; ce_b = 1'b1; addr_b = 11'h055; cycle();
        check("mid_rst_a", do_a, 8'h00);
        check("mid_rst_b", do_b, 8'h00);
        idle(); ce_a = 1'b1; addr_a = 11'h055; cycle();
        check("post_rst", do_a, 8'h55);

        idle(); ce_a = 1'b1; we_a = 1'b1; addr_a = 11'h200; di_a = 8'h01;
        ce_b = 1'b1; we_b = 1'b1; addr_b = 11'h200; di_b = 8'h02; cycle();
        rd_b(11'h200); cycle();
        check("collide", do_b, 8'h01);

        for (int n = 0; n < 1500; n++) begin
            rst    = ($urandom_range(0, 63) == 0);
            ce_a   = ($urandom_range(0, 3) != 0);
            we_a   = $urandom_range(0, 1);
            oe_a   = ($urandom_range(0, 7) != 0);
            addr_a = 11'h300 | 11'($urandom_range(0, 7));
            di_a   = 8'($urandom);
            ce_b   = ($urandom_range(0, 3) != 0);
            we_b   = $urandom_range(0, 1);
            oe_b   = ($urandom_range(0, 7) != 0);
            addr_b = 11'h300 | 11'($urandom_range(0, 7));
            di_b   = 8'($urandom);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
